// File: rtl/binary_gates_unit_if.sv
// rtl/binary_gates_unit_if.sv - operand and result bundle for binary_gates_unit
interface binary_gates_unit_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] and_out, or_out, xor_out, xnor_out;
  logic [WIDTH-1:0] shl_out, shr_out, sshl_out, sshr_out;
  logic             logic_and_out, logic_or_out, eqx_out, nex_out;
  logic             lt_out, le_out, eq_out, ne_out, ge_out, gt_out;
  logic [WIDTH-1:0] add_out, sub_out, mul_out, div_out, mod_out, pow_out;

  modport master (
    output a, b,
    input  and_out, or_out, xor_out, xnor_out, shl_out, shr_out, sshl_out, sshr_out,
    input  logic_and_out, logic_or_out, eqx_out, nex_out,
    input  lt_out, le_out, eq_out, ne_out, ge_out, gt_out,
    input  add_out, sub_out, mul_out, div_out, mod_out, pow_out
  );

  modport slave (
    input  a, b,
    output and_out, or_out, xor_out, xnor_out, shl_out, shr_out, sshl_out, sshr_out,
    output logic_and_out, logic_or_out, eqx_out, nex_out,
    output lt_out, le_out, eq_out, ne_out, ge_out, gt_out,
    output add_out, sub_out, mul_out, div_out, mod_out, pow_out
  );
endinterface

// File: rtl/binary_gates_unit.sv
// rtl/binary_gates_unit.sv - registered 24-operator reference block
// BINARY_GATES_IN_REG_EN adds a resettable operand register stage (latency 2).
module binary_gates_unit #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  binary_gates_unit_if.slave bus
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

`ifdef BINARY_GATES_IN_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      opa <= '0;
      opb <= '0;
    end else begin
      opa <= bus.a;
      opb <= bus.b;
    end
  end
`else
  assign opa = bus.a;
  assign opb = bus.b;
`endif

  // Square-and-multiply unrolled over exponent bits; every product wraps mod 2^WIDTH.
  function automatic logic [WIDTH-1:0] pow_mod(input logic [WIDTH-1:0] base_in,
                                               input logic [WIDTH-1:0] exp_in);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    acc  = WIDTH'(1);
    base = base_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (exp_in[i]) acc = acc * base;
      base = base * base;
    end
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.and_out       <= '0;
      bus.or_out        <= '0;
      bus.xor_out       <= '0;
      bus.xnor_out      <= '0;
      bus.shl_out       <= '0;
      bus.shr_out       <= '0;
      bus.sshl_out      <= '0;
      bus.sshr_out      <= '0;
      bus.logic_and_out <= 1'b0;
      bus.logic_or_out  <= 1'b0;
      bus.eqx_out       <= 1'b0;
      bus.nex_out       <= 1'b0;
      bus.lt_out        <= 1'b0;
      bus.le_out        <= 1'b0;
      bus.eq_out        <= 1'b0;
      bus.ne_out        <= 1'b0;
      bus.ge_out        <= 1'b0;
      bus.gt_out        <= 1'b0;
      bus.add_out       <= '0;
      bus.sub_out       <= '0;
      bus.mul_out       <= '0;
      bus.div_out       <= '0;
      bus.mod_out       <= '0;
      bus.pow_out       <= '0;
    end else begin
      bus.and_out       <= opa & opb;
      bus.or_out        <= opa | opb;
      bus.xor_out       <= opa ^ opb;
      bus.xnor_out      <= ~(opa ^ opb);
      bus.shl_out       <= opa << opb;
      bus.shr_out       <= opa >> opb;
      bus.sshl_out      <= opa <<< opb;
      bus.sshr_out      <= $signed(opa) >>> opb;
      bus.logic_and_out <= (opa != '0) && (opb != '0);
      bus.logic_or_out  <= (opa != '0) || (opb != '0);
      bus.eqx_out       <= (opa === opb);
      bus.nex_out       <= (opa !== opb);
      bus.lt_out        <= (opa < opb);
      bus.le_out        <= (opa <= opb);
      bus.eq_out        <= (opa == opb);
      bus.ne_out        <= (opa != opb);
      bus.ge_out        <= (opa >= opb);
      bus.gt_out        <= (opa > opb);
      bus.add_out       <= opa + opb;
      bus.sub_out       <= opa - opb;
      bus.mul_out       <= opa * opb;
      // Divide by zero yields quotient 0 and passes the dividend through as remainder.
      bus.div_out       <= (opb == '0) ? '0  : opa / opb;
      bus.mod_out       <= (opb == '0) ? opa : opa % opb;
      bus.pow_out       <= pow_mod(opa, opb);
    end
  end

endmodule

// File: tb/tb_binary_gates_unit.sv
// tb/tb_binary_gates_unit.sv - random and directed bench for binary_gates_unit
module tb_binary_gates_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_gates_unit_if #(.WIDTH(1)) bus1 ();
  binary_gates_unit_if #(.WIDTH(8)) bus8 ();

  binary_gates_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  binary_gates_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    bit r;
    int a1;
    int b1;
    int a8;
    int b8;
  } entry_t;

  entry_t hist[$];
  int compared   = 0;
  int mismatched = 0;

  string names [24] = '{"and", "or", "xor", "xnor", "shl", "shr", "sshl", "sshr",
                        "logic_and", "logic_or", "eqx", "nex", "lt", "le", "eq", "ne",
                        "ge", "gt", "add", "sub", "mul", "div", "mod", "pow"};

  // Known answers for WIDTH=1; bit k is the expected value of names[k], index = a*2+b.
  logic [23:0] tbl [4] = '{24'h816408, 24'h0CBA06, 24'hCF8AF6, 24'hB1678B};

  logic [7:0] o1 [24];
  logic [7:0] o8 [24];

  assign o1[0]  = 8'(bus1.and_out);        assign o8[0]  = bus8.and_out;
  assign o1[1]  = 8'(bus1.or_out);         assign o8[1]  = bus8.or_out;
  assign o1[2]  = 8'(bus1.xor_out);        assign o8[2]  = bus8.xor_out;
  assign o1[3]  = 8'(bus1.xnor_out);       assign o8[3]  = bus8.xnor_out;
  assign o1[4]  = 8'(bus1.shl_out);        assign o8[4]  = bus8.shl_out;
  assign o1[5]  = 8'(bus1.shr_out);        assign o8[5]  = bus8.shr_out;
  assign o1[6]  = 8'(bus1.sshl_out);       assign o8[6]  = bus8.sshl_out;
  assign o1[7]  = 8'(bus1.sshr_out);       assign o8[7]  = bus8.sshr_out;
  assign o1[8]  = 8'(bus1.logic_and_out);  assign o8[8]  = 8'(bus8.logic_and_out);
  assign o1[9]  = 8'(bus1.logic_or_out);   assign o8[9]  = 8'(bus8.logic_or_out);
  assign o1[10] = 8'(bus1.eqx_out);        assign o8[10] = 8'(bus8.eqx_out);
  assign o1[11] = 8'(bus1.nex_out);        assign o8[11] = 8'(bus8.nex_out);
  assign o1[12] = 8'(bus1.lt_out);         assign o8[12] = 8'(bus8.lt_out);
  assign o1[13] = 8'(bus1.le_out);         assign o8[13] = 8'(bus8.le_out);
  assign o1[14] = 8'(bus1.eq_out);         assign o8[14] = 8'(bus8.eq_out);
  assign o1[15] = 8'(bus1.ne_out);         assign o8[15] = 8'(bus8.ne_out);
  assign o1[16] = 8'(bus1.ge_out);         assign o8[16] = 8'(bus8.ge_out);
  assign o1[17] = 8'(bus1.gt_out);         assign o8[17] = 8'(bus8.gt_out);
  assign o1[18] = 8'(bus1.add_out);        assign o8[18] = bus8.add_out;
  assign o1[19] = 8'(bus1.sub_out);        assign o8[19] = bus8.sub_out;
  assign o1[20] = 8'(bus1.mul_out);        assign o8[20] = bus8.mul_out;
  assign o1[21] = 8'(bus1.div_out);        assign o8[21] = bus8.div_out;
  assign o1[22] = 8'(bus1.mod_out);        assign o8[22] = bus8.mod_out;
  assign o1[23] = 8'(bus1.pow_out);        assign o8[23] = bus8.pow_out;

  // Reference: integer arithmetic on w-bit unsigned values.
  function automatic longint unsigned ref_op(int w, int k, longint unsigned a, longint unsigned b);
    longint unsigned m   = (64'd1 << w) - 1;
    longint unsigned sgn = (a >> (w - 1)) & 1;
    longint unsigned acc = 1;
    case (k)
      0:  return a & b;
      1:  return a | b;
      2:  return a ^ b;
      3:  return ~(a ^ b) & m;
      4, 6: return (b >= longint'(w)) ? 0 : (a << b) & m;
      5:  return (b >= longint'(w)) ? 0 : a >> b;
      7: begin
        if (b >= longint'(w)) return (sgn != 0) ? m : 0;
        return (a >> b) | ((sgn != 0) ? (m & ~(m >> b)) : 0);
      end
      8:  return (a != 0 && b != 0) ? 1 : 0;
      9:  return (a != 0 || b != 0) ? 1 : 0;
      10, 14: return (a == b) ? 1 : 0;
      11, 15: return (a != b) ? 1 : 0;
      12: return (a < b) ? 1 : 0;
      13: return (a <= b) ? 1 : 0;
      16: return (a >= b) ? 1 : 0;
      17: return (a > b) ? 1 : 0;
      18: return (a + b) & m;
      19: return (a - b) & m;
      20: return (a * b) & m;
      21: return (b == 0) ? 0 : a / b;
      22: return (b == 0) ? a : a % b;
      23: begin
        for (longint unsigned i = 0; i < b; i++) acc = (acc * a) & m;
        return acc;
      end
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, longint unsigned obs, longint unsigned exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    entry_t cur;
    entry_t src;
    cur = hist[$];
    src = cur;
`ifdef BINARY_GATES_IN_REG_EN
    src = hist[$-1];
    if (src.r) begin
      src.a1 = 0; src.b1 = 0; src.a8 = 0; src.b8 = 0;
    end
`endif
    for (int k = 0; k < 24; k++) begin
      chk($sformatf("w1_%s a=%0d b=%0d rst=%0d", names[k], src.a1, src.b1, cur.r), o1[k],
          cur.r ? 0 : ref_op(1, k, src.a1, src.b1));
      chk($sformatf("w8_%s a=%0h b=%0h rst=%0d", names[k], src.a8, src.b8, cur.r), o8[k],
          cur.r ? 0 : ref_op(8, k, src.a8, src.b8));
    end
  endtask

  task automatic step(bit r, int a1, int b1, int a8, int b8);
    entry_t e;
    rst    = r;
    bus1.a = 1'(a1);
    bus1.b = 1'(b1);
    bus8.a = 8'(a8);
    bus8.b = 8'(b8);
    @(posedge clk);
    e = '{r, a1 & 1, b1 & 1, a8 & 255, b8 & 255};
    hist.push_back(e);
    if (hist.size() > 4) void'(hist.pop_front());
    @(negedge clk);
    check_cycle();
  endtask

  int ba [12] = '{0, 0, 1, 128, 128, 128, 255, 5, 2, 3, 127, 200};
  int bb [12] = '{0, 1, 0, 7, 8, 200, 255, 0, 7, 5, 1, 13};

  initial begin
    step(1, 1, 1, 1, 1);
    step(1, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);
    step(0, 1, 1, 1, 1);

    for (int v = 0; v < 4; v++) begin
      for (int n = 0; n < 10; n++) step(0, v >> 1, v & 1, ba[v + 4], bb[v + 4]);
      for (int k = 0; k < 24; k++)
        chk($sformatf("table%0d_%s", v, names[k]), o1[k], 64'((tbl[v] >> k) & 24'd1));
    end

    for (int rep = 0; rep < 2; rep++)
      for (int v = 0; v < 4; v++) step(0, v >> 1, v & 1, 255 - v, v * 3);

    for (int i = 0; i < 12; i++) step(0, i & 1, (i >> 1) & 1, ba[i], bb[i]);

    for (int i = 0; i < 300; i++) begin
      int b8;
      if ($urandom_range(0, 3) == 0) b8 = $urandom_range(0, 15);
      else if ($urandom_range(0, 9) == 0) b8 = 0;
      else b8 = $urandom_range(0, 255);
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 255), b8);
    end

    step(1, 1, 0, 77, 3);
    step(0, 0, 1, 9, 2);
    step(0, 1, 0, 33, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
